// File: rtl/bf_sequencer.sv
// Arbitrage-engine phase scheduler: init, NODES-1 relax passes, then cycle detect, sharing vertmat/adjmat ports.
// States: IDLE accept updates | *_RST launch pulse | *_WAIT await done/watchdog | FINISH run_done pulse.
module bf_sequencer #(
  parameter int NODES    = 16,
  parameter int ADDR_W   = 4,
  parameter int WEIGHT_W = 32,
  parameter int VERT_W   = 36,
  parameter int TIMEOUT  = 65535,
  parameter int AUTO_RUN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                upd_valid,
  input  logic [ADDR_W-1:0]   upd_row,
  input  logic [ADDR_W-1:0]   upd_col,
  input  logic [WEIGHT_W-1:0] upd_weight,
  output logic                upd_ready,
  output logic                init_reset,
  input  logic                init_done,
  input  logic [ADDR_W-1:0]   init_vertmat_addr,
  input  logic                init_vertmat_we,
  input  logic [VERT_W-1:0]   init_vertmat_wdata,
  output logic                relax_reset,
  input  logic                relax_done,
  input  logic [ADDR_W-1:0]   relax_vertmat_addr,
  input  logic                relax_vertmat_we,
  input  logic [VERT_W-1:0]   relax_vertmat_wdata,
  input  logic [ADDR_W-1:0]   relax_adjmat_row_addr,
  input  logic [ADDR_W-1:0]   relax_adjmat_col_addr,
  output logic                cycle_reset,
  input  logic                cycle_done,
  input  logic [ADDR_W-1:0]   cycle_vertmat_addr,
  input  logic [ADDR_W-1:0]   cycle_adjmat_row_addr,
  input  logic [ADDR_W-1:0]   cycle_adjmat_col_addr,
  output logic [ADDR_W-1:0]   vertmat_addr,
  output logic                vertmat_we,
  output logic [VERT_W-1:0]   vertmat_wdata,
  output logic [ADDR_W-1:0]   adjmat_row_addr,
  output logic [ADDR_W-1:0]   adjmat_col_addr,
  output logic                adjmat_we,
  output logic [WEIGHT_W-1:0] adjmat_wdata,
  output logic                busy,
  output logic                run_done,
  output logic [ADDR_W-1:0]   pass_count,
  output logic                timeout_err
);

  localparam int                WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_PASS = ADDR_W'(NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_RST,
    S_INIT_WAIT,
    S_RELAX_RST,
    S_RELAX_WAIT,
    S_CYCLE_RST,
    S_CYCLE_WAIT,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic              start_pend_q, start_pend_d;
  logic              dirty_q, dirty_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ADDR_W-1:0] pass_q, pass_d;
  logic              terr_q, terr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_pend_q <= 1'b0;
      dirty_q      <= 1'b0;
      wd_q         <= '0;
      pass_q       <= '0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      dirty_q      <= dirty_d;
      wd_q         <= wd_d;
      pass_q       <= pass_d;
      terr_q       <= terr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    start_pend_d    = start_pend_q;
    dirty_d         = dirty_q;
    wd_d            = wd_q;
    pass_d          = pass_q;
    terr_d          = terr_q;
    upd_ready       = 1'b0;
    init_reset      = 1'b0;
    relax_reset     = 1'b0;
    cycle_reset     = 1'b0;
    vertmat_addr    = '0;
    vertmat_we      = 1'b0;
    vertmat_wdata   = '0;
    adjmat_row_addr = '0;
    adjmat_col_addr = '0;
    adjmat_we       = 1'b0;
    adjmat_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        upd_ready       = 1'b1;
        adjmat_we       = upd_valid;
        adjmat_row_addr = upd_row;
        adjmat_col_addr = upd_col;
        adjmat_wdata    = upd_weight;
        if (upd_valid) dirty_d = 1'b1;
        if (start) start_pend_d = 1'b1;
        // a pending update always wins so the run sees the freshest prices
        if ((start || start_pend_q || ((AUTO_RUN != 0) && dirty_q)) && !upd_valid) begin
          state_d      = S_INIT_RST;
          start_pend_d = 1'b0;
          dirty_d      = 1'b0;
          terr_d       = 1'b0;
          pass_d       = ADDR_W'(1);
        end
      end
      S_INIT_RST, S_INIT_WAIT: begin
        vertmat_addr  = init_vertmat_addr;
        vertmat_we    = init_vertmat_we;
        vertmat_wdata = init_vertmat_wdata;
        if (state_q == S_INIT_RST) begin
          init_reset = 1'b1;
          wd_d       = '0;
          state_d    = S_INIT_WAIT;
        end else begin
          wd_d = wd_q + 1'b1;
          if (init_done) state_d = S_RELAX_RST;
          else if (wd_q == WD_LAST) begin
            terr_d  = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_RELAX_RST, S_RELAX_WAIT: begin
        vertmat_addr    = relax_vertmat_addr;
        vertmat_we      = relax_vertmat_we;
        vertmat_wdata   = relax_vertmat_wdata;
        adjmat_row_addr = relax_adjmat_row_addr;
        adjmat_col_addr = relax_adjmat_col_addr;
        if (state_q == S_RELAX_RST) begin
          relax_reset = 1'b1;
          wd_d        = '0;
          state_d     = S_RELAX_WAIT;
        end else begin
          wd_d = wd_q + 1'b1;
          if (relax_done) begin
            if (pass_q == LAST_PASS) state_d = S_CYCLE_RST;
            else begin
              pass_d  = pass_q + 1'b1;
              state_d = S_RELAX_RST;
            end
          end else if (wd_q == WD_LAST) begin
            terr_d  = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_CYCLE_RST, S_CYCLE_WAIT: begin
        vertmat_addr    = cycle_vertmat_addr;
        adjmat_row_addr = cycle_adjmat_row_addr;
        adjmat_col_addr = cycle_adjmat_col_addr;
        if (state_q == S_CYCLE_RST) begin
          cycle_reset = 1'b1;
          wd_d        = '0;
          state_d     = S_CYCLE_WAIT;
        end else begin
          wd_d = wd_q + 1'b1;
          if (cycle_done) state_d = S_FINISH;
          else if (wd_q == WD_LAST) begin
            terr_d  = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign run_done    = (state_q == S_FINISH);
  assign pass_count  = pass_q;
  assign timeout_err = terr_q;

endmodule
